// File: rtl/double_to_sig16b.sv
// double_to_sig16b: converts an IEEE-754 binary64 operand to a saturating
// 16-bit two's-complement integer with round-half-away-from-zero.
// The mantissa is shifted right one bit per cycle, so latency depends on
// the operand's exponent. Specials and out-of-range values skip the shifter.
module double_to_sig16b (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] double,
    output logic [15:0] sig16b,
    output logic        stop,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        SHIFT  = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_NAN    = 3'd2,
        CLS_INF    = 3'd3,
        CLS_OVF    = 3'd4,
        CLS_MIN    = 3'd5
    } cls_t;

    state_t      state_r;
    cls_t        cls_r;
    logic        sign_r;
    logic [10:0] exp_r;
    logic [52:0] mant_r;
    logic        guard_r;
    logic [5:0]  cnt_r;

    cls_t        cls_s;
    logic [5:0]  n_s;
    logic [16:0] mag_s;
    logic [15:0] res_s;
    logic        ovf_res_s;

    // Classify the captured operand and derive the shift count for normal values.
    always_comb begin
        cls_s = CLS_NORMAL;
        n_s   = 6'd0;
        if ((exp_r == 11'h7FF) && (mant_r[51:0] != 52'd0)) begin
            cls_s = CLS_NAN;
        end else if (exp_r == 11'h7FF) begin
            cls_s = CLS_INF;
        end else if (sign_r && (exp_r == 11'd1038) && (mant_r[51:0] == 52'd0)) begin
            cls_s = CLS_MIN;
        end else if (exp_r >= 11'd1038) begin
            cls_s = CLS_OVF;
        end else if (exp_r < 11'd1022) begin
            cls_s = CLS_ZERO;
        end else begin
            // exp in 1022..1037: n = 1075 - exp, which modulo 64 is 51 - exp[5:0]
            cls_s = CLS_NORMAL;
            n_s   = 6'd51 - exp_r[5:0];
        end
    end

    // Round the shifted mantissa and saturate according to the operand class.
    always_comb begin
        // After at least 38 shifts only the low 15 mantissa bits can be set.
        mag_s     = {2'b00, mant_r[14:0]} + {16'd0, guard_r};
        res_s     = 16'h0000;
        ovf_res_s = 1'b0;
        case (cls_r)
            CLS_NAN: begin
                res_s     = 16'h0000;
                ovf_res_s = 1'b1;
            end
            CLS_INF, CLS_OVF: begin
                res_s     = sign_r ? 16'h8000 : 16'h7FFF;
                ovf_res_s = 1'b1;
            end
            CLS_MIN: begin
                res_s     = 16'h8000;
                ovf_res_s = 1'b0;
            end
            CLS_ZERO: begin
                res_s     = 16'h0000;
                ovf_res_s = 1'b0;
            end
            CLS_NORMAL: begin
                if (!sign_r) begin
                    if (mag_s <= 17'd32767) begin
                        res_s     = mag_s[15:0];
                        ovf_res_s = 1'b0;
                    end else begin
                        res_s     = 16'h7FFF;
                        ovf_res_s = 1'b1;
                    end
                end else begin
                    if (mag_s <= 17'd32768) begin
                        res_s     = 16'd0 - mag_s[15:0];
                        ovf_res_s = 1'b0;
                    end else begin
                        res_s     = 16'h8000;
                        ovf_res_s = 1'b1;
                    end
                end
            end
            default: begin
                res_s     = 16'h0000;
                ovf_res_s = 1'b0;
            end
        endcase
    end

    // Conversion sequencer with registered result and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cls_r   <= CLS_NORMAL;
            sign_r  <= 1'b0;
            exp_r   <= 11'd0;
            mant_r  <= 53'd0;
            guard_r <= 1'b0;
            cnt_r   <= 6'd0;
            sig16b  <= 16'h0000;
            stop    <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sign_r  <= double[63];
                        exp_r   <= double[62:52];
                        mant_r  <= {1'b1, double[51:0]};
                        guard_r <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= UNPACK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                UNPACK: begin
                    cls_r <= cls_s;
                    cnt_r <= n_s;
                    if (cls_s == CLS_NORMAL) begin
                        state_r <= SHIFT;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                SHIFT: begin
                    mant_r  <= mant_r >> 1;
                    guard_r <= mant_r[0];
                    cnt_r   <= cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        state_r <= ROUND;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                ROUND: begin
                    sig16b  <= res_s;
                    ovf     <= ovf_res_s;
                    stop    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    stop    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    stop    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_to_sig16b.sv
// Self-checking bench for double_to_sig16b: directed operands plus random
// operands, each compared against a real-arithmetic reference model.
module tb_double_to_sig16b;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] dbl;
    logic [15:0] sig16b;
    logic        stop;
    logic        busy;
    logic        ovf;

    int compared;
    int mismatched;

    double_to_sig16b dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .double (dbl),
        .sig16b (sig16b),
        .stop   (stop),
        .busy   (busy),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level conversion with round-half-away-from-zero.
    task automatic ref_model(input logic [63:0] d, output logic [15:0] r,
                             output logic o, output int n);
        real x, mag, fr, p;
        int  t, m, k;
        logic s;
        logic [10:0] e;
        s = d[63];
        e = d[62:52];
        n = 0;
        r = 16'h0000;
        o = 1'b0;
        if (e == 11'h7FF && d[51:0] != 52'd0) begin
            r = 16'h0000; o = 1'b1;
        end else if (e == 11'h7FF) begin
            r = s ? 16'h8000 : 16'h7FFF; o = 1'b1;
        end else begin
            x   = $bitstoreal(d);
            mag = s ? -x : x;
            if (mag < 0.5) begin
                r = 16'h0000; o = 1'b0;
            end else if (mag >= 32768.0) begin
                if (s && mag == 32768.0) begin
                    r = 16'h8000; o = 1'b0;
                end else begin
                    r = s ? 16'h8000 : 16'h7FFF; o = 1'b1;
                end
            end else begin
                t  = $rtoi(mag);
                fr = mag - t;
                m  = t + ((fr >= 0.5) ? 1 : 0);
                k  = -1;
                p  = 1.0;
                while (p <= mag) begin
                    k++;
                    p = p * 2.0;
                end
                n = 52 - k;
                if (!s) begin
                    if (m > 32767) begin r = 16'h7FFF; o = 1'b1; end
                    else begin r = m[15:0]; o = 1'b0; end
                end else begin
                    if (m > 32768) begin r = 16'h8000; o = 1'b1; end
                    else begin r = 16'(-m); o = 1'b0; end
                end
            end
        end
    endtask

    // One conversion; optionally pulses start mid-conversion with another operand.
    task automatic run_conv(input logic [63:0] d, input string tag, input bit intr);
        logic [15:0] er;
        logic        eo;
        int          en;
        int          edges;
        int          stops;
        ref_model(d, er, eo, en);
        @(negedge clk);
        dbl   = d;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, busy, 1'b1);
        while (stop !== 1'b1 && edges < 100) begin
            if (intr && edges == 4) begin
                start = 1'b1;
                dbl   = 64'h40E0000000000000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, edges, 3 + en);
        check({tag, "_sig16b"}, sig16b, er);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_busy_done"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_stop_1cyc"}, stop, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_held"}, sig16b, er);
        if (intr) begin
            stops = 0;
            repeat (60) begin
                @(negedge clk);
                if (stop) stops++;
            end
            check({tag, "_extra_stop"}, stops, 0);
            check({tag, "_first_operand"}, sig16b, er);
        end
    endtask

    initial begin
        int          stops;
        logic [63:0] rnd;
        logic [51:0] frac;
        logic [10:0] e;
        logic        s;
        int          mode;
        compared   = 0;
        mismatched = 0;
        start      = 1'b0;
        dbl        = 64'd0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sig16b", sig16b, 16'h0000);
        check("rst_stop", stop, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b1;

        run_conv(64'h4022000000000000, "nine", 1'b0);
        check("nine_const", sig16b, 16'h0009);
        run_conv(64'h3FF0000000000000, "one", 1'b0);
        run_conv(64'hC004000000000000, "m2p5", 1'b0);
        check("m2p5_const", sig16b, 16'hFFFD);
        run_conv(64'h3FE0000000000000, "half", 1'b0);
        run_conv(64'h40E3880000000000, "40000", 1'b0);
        check("40000_const", sig16b, 16'h7FFF);
        run_conv(64'hC0E0000000000000, "m32768", 1'b0);
        check("m32768_const", sig16b, 16'h8000);
        run_conv(64'h7FF8000000000000, "nan", 1'b0);
        run_conv(64'h3FD0000000000000, "quarter", 1'b0);
        run_conv(64'h4022000000000000, "ignore_start", 1'b1);
        run_conv(64'h40E3880000000000, "pre_reset", 1'b0);

        // Abort a conversion in SHIFT with an asynchronous reset.
        @(negedge clk);
        dbl   = 64'h3FF0000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_sig16b", sig16b, 16'h0000);
        check("abort_ovf", ovf, 1'b0);
        check("abort_stop", stop, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        stops = 0;
        repeat (70) begin
            @(negedge clk);
            if (stop) stops++;
        end
        check("abort_no_stop", stops, 0);
        run_conv(64'h3FF0000000000000, "after_reset", 1'b0);

        for (int i = 0; i < 40; i++) begin
            rnd  = {$urandom, $urandom};
            frac = rnd[51:0];
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                e = 11'h7FF;
            end else if (mode == 1) begin
                e    = 11'h7FF;
                frac = 52'd0;
            end else begin
                e = 11'($urandom_range(1018, 1040));
            end
            if (mode == 2) frac = 52'd0;
            if (mode == 3) frac = {frac[51:36], 36'd0};
            run_conv({s, e, frac}, "rand", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/double_to_sig16b.md
DOUBLE_TO_SIG16B -- requirements
Module: double_to_sig16b

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-004 SHALL have port double, input, 64, IEEE-754 binary64 operand, captured on the edge that accepts start.
REQ-005 SHALL have port sig16b, output, 16, two's-complement result, registered, held until the next conversion completes.
REQ-006 SHALL have port stop, output, 1, one-cycle done pulse, high in the same cycle sig16b first shows the new result.
REQ-007 SHALL have port busy, output, 1, high from the cycle after start is accepted until stop falls.
REQ-008 SHALL have port ovf, output, 1, set for saturated or NaN results, updated together with sig16b.

Function
REQ-009 SHALL implement FSM states IDLE, UNPACK, SHIFT, ROUND and DONE.
REQ-010 SHALL move IDLE->UNPACK on a rising edge with start=1, capturing sign s, exponent e[10:0] and mantissa m = {1, frac[51:0]} (53 bits).
REQ-011 SHALL ignore start in every state except IDLE, with no effect on captured data.
REQ-012 In UNPACK, SHALL let k = e-1023 and classify the operand, in priority order: NaN (e=0x7FF, frac!=0); Inf (e=0x7FF, frac=0); exact -32768 (s=1, k=15, frac=0); overflow (k>=15); zero (e<1022, including zero and subnormals); otherwise normal.
REQ-013 For normal operands, SHALL set shift count n = 52-k (range 38..53) and enter SHIFT; all other classes SHALL go directly to ROUND with n=0.
REQ-014 In SHIFT, SHALL logically shift the 53-bit mantissa right by exactly one bit per cycle for n cycles, holding the last bit shifted out as guard g.
REQ-015 In ROUND, SHALL form magnitude M = shifted mantissa + g, giving round-half-away-from-zero.
REQ-016 Results SHALL be: NaN -> 0x0000, ovf=1; Inf or overflow -> 0x7FFF (s=0) or 0x8000 (s=1), ovf=1; exact -32768 -> 0x8000, ovf=0; zero -> 0x0000, ovf=0.
REQ-017 For normal operands with s=0, SHALL output M if M<=32767, else 0x7FFF with ovf=1.
REQ-018 For normal operands with s=1, SHALL output -M if M<=32768, else 0x8000 with ovf=1.
REQ-019 SHALL compute M in at least 17 bits so that a rounding carry is never lost.
REQ-020 ROUND->DONE SHALL load sig16b and ovf; DONE SHALL assert stop for exactly one cycle and then return to IDLE.
REQ-021 Latency: stop SHALL be high in the cycle after the (3+n)th rising edge counted from, and including, the edge that accepted start.
REQ-022 A new start SHALL be accepted at the earliest on the edge on which the FSM leaves DONE.
REQ-023 sig16b and ovf SHALL change only on ROUND->DONE.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, sig16b=0x0000, stop=0, busy=0, ovf=0, and clear all internal registers.
REQ-025 Reset during any non-IDLE state SHALL abort the conversion; no stop pulse SHALL be produced for it.
REQ-026 The first start SHALL be accepted on the first rising edge after rst returns high.

Verification
REQ-027 double=0x4022000000000000 (9.0) with a start pulse SHALL give sig16b=0x0009, ovf=0, and stop in the cycle after edge 52 (n=49).
REQ-028 0x3FF0000000000000 (1.0) SHALL give 0x0001 (n=52).
REQ-029 0xC004000000000000 (-2.5) SHALL give 0xFFFD (-3).
REQ-030 0x3FE0000000000000 (0.5) SHALL give 0x0001 (n=53).
REQ-031 0x40E3880000000000 (40000.0) SHALL give 0x7FFF with ovf=1 and stop after edge 3.
REQ-032 0xC0E0000000000000 SHALL give 0x8000 with ovf=0.
REQ-033 0x7FF8000000000000 (NaN) SHALL give 0x0000 with ovf=1.
REQ-034 0x3FD0000000000000 (0.25) SHALL give 0x0000 after edge 3.
REQ-035 A start pulse while busy=1 SHALL be ignored: only one stop, and the result SHALL come from the first operand.
REQ-036 rst pulsed low mid-SHIFT SHALL immediately give all outputs 0 with no stop, and the next start SHALL convert normally.
